// File: rtl/bubble_output_serializer_if.sv
// Signal bundle between the bubble timing generator, the page/bootloop
// buffer RAM and the bubble output serializer.
//   ACCTYPE      : access type (3'b110 BOOT, 3'b111 USER, bit[1]=0 idle)
//   BOUTCYCLENUM : output cycle number, 13'h1FFF = not started
//   nBOUTCLKEN   : single-cycle active-low launch strobe
//   nNOBUBBLE    : active-low "force no bubble" for the current launch
//   BUFADDR      : buffer RAM word address
//   BUFRD        : one-cycle buffer RAM read strobe
//   BUFDATA      : buffer RAM read data, two cycles after BUFRD
//   DOUT         : serial bubble data {odd, even}, 0 = bubble
//   UNDERRUN     : sticky "launch found no valid word" flag
// modport master is the serializer side, modport slave is the environment.
interface bubble_output_serializer_if;
    logic [2:0]  ACCTYPE;
    logic [12:0] BOUTCYCLENUM;
    logic        nBOUTCLKEN;
    logic        nNOBUBBLE;
    logic [10:0] BUFADDR;
    logic        BUFRD;
    logic [15:0] BUFDATA;
    logic [1:0]  DOUT;
    logic        UNDERRUN;

    modport master (
        input  ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, nNOBUBBLE, BUFDATA,
        output BUFADDR, BUFRD, DOUT, UNDERRUN
    );

    modport slave (
        output ACCTYPE, BOUTCYCLENUM, nBOUTCLKEN, nNOBUBBLE, BUFDATA,
        input  BUFADDR, BUFRD, DOUT, UNDERRUN
    );
endinterface

// File: rtl/bubble_output_serializer.sv
// Bubble output serializer: prefetches the 16-bit buffer word addressed by
// the current output cycle number, then on each launch strobe drives one
// bit pair of that word onto the two serial bubble lines for PULSE_LEN
// MCLK cycles before returning them to idle (2'b11).
// Ports:
//   MCLK   : master clock (only clock)
//   SYSRST : synchronous active-high reset
//   bus    : timing inputs, buffer RAM bus and serial outputs (master side)
module bubble_output_serializer #(
    parameter int          PULSE_LEN = 120,
    parameter logic [10:0] USER_BASE = 11'd1024
) (
    input logic                        MCLK,
    input logic                        SYSRST,
    bubble_output_serializer_if.master bus
);
    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT1, WAIT2} fetch_state_t;

    fetch_state_t     state;
    logic [10:0]      last_addr;
    logic             word_valid;
    logic [15:0]      word_reg;
    logic [CNT_W-1:0] pulse_cnt;

    logic [9:0]  word_index;
    logic [2:0]  pair_index;
    logic [10:0] target_addr;
    logic        active;
    logic        word_hit;
    logic [1:0]  launch_pair;

    assign word_index  = bus.BOUTCYCLENUM[12:3];
    assign pair_index  = bus.BOUTCYCLENUM[2:0];
    // ACCTYPE[0] separates USER (offset into the user page area) from BOOT.
    assign target_addr = bus.ACCTYPE[0] ? (USER_BASE + {1'b0, word_index})
                                        : {1'b0, word_index};
    assign active      = bus.ACCTYPE[1] && (bus.BOUTCYCLENUM != 13'h1FFF);
    assign word_hit    = word_valid && (last_addr == target_addr);
    // A stored 1 means "bubble", which is driven as 0 on the line.
    assign launch_pair = ~{word_reg[{pair_index, 1'b1}], word_reg[{pair_index, 1'b0}]};

    // Fetch FSM: the read strobe, address and last_addr are registered when
    // entering REQ, so BUFRD is high exactly while the FSM sits in REQ.
    always_ff @(posedge MCLK) begin
        if (SYSRST) begin
            state      <= IDLE;
            bus.BUFRD  <= 1'b0;
            bus.BUFADDR <= '0;
            last_addr  <= '0;
            word_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!active) begin
                        word_valid <= 1'b0;
                    end else if (!word_hit) begin
                        state       <= REQ;
                        bus.BUFRD   <= 1'b1;
                        bus.BUFADDR <= target_addr;
                        last_addr   <= target_addr;
                        word_valid  <= 1'b0;
                    end
                end
                REQ: begin
                    bus.BUFRD <= 1'b0;
                    state     <= WAIT1;
                end
                WAIT1: state <= WAIT2;
                WAIT2: begin
                    // RAM data is valid now; a target change seen during the
                    // wait is picked up by the IDLE compare next cycle.
                    word_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word register carries data only; word_valid qualifies it.
    always_ff @(posedge MCLK) begin
        if (state == WAIT2) begin
            word_reg <= bus.BUFDATA;
        end
    end

    // Output pulse generator: access end beats launch, launch beats expiry.
    always_ff @(posedge MCLK) begin
        if (SYSRST) begin
            bus.DOUT     <= 2'b11;
            bus.UNDERRUN <= 1'b0;
            pulse_cnt    <= '0;
        end else if (!bus.ACCTYPE[2]) begin
            bus.DOUT  <= 2'b11;
            pulse_cnt <= '0;
        end else if (!bus.nBOUTCLKEN) begin
            pulse_cnt <= CNT_W'(PULSE_LEN - 1);
            if (!bus.ACCTYPE[1] || !bus.nNOBUBBLE) begin
                bus.DOUT <= 2'b11;
            end else if (word_hit) begin
                bus.DOUT <= launch_pair;
            end else begin
                bus.DOUT     <= 2'b11;
                bus.UNDERRUN <= 1'b1;
            end
        end else if (pulse_cnt == '0) begin
            bus.DOUT <= 2'b11;
        end else begin
            pulse_cnt <= pulse_cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_bubble_output_serializer.sv
// Bench for bubble_output_serializer: buffer RAM model with two-cycle read
// latency, an event-level reference model checked every cycle, and directed
// scenarios with hand-computed expectations.
module tb_bubble_output_serializer;
    localparam int PULSE_LEN = 120;

    logic MCLK = 1'b0;
    logic SYSRST;

    bubble_output_serializer_if bus ();

    bubble_output_serializer #(
        .PULSE_LEN (PULSE_LEN),
        .USER_BASE (11'd1024)
    ) dut (
        .MCLK   (MCLK),
        .SYSRST (SYSRST),
        .bus    (bus.master)
    );

    always #5 MCLK = ~MCLK;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:2047];

    // Buffer RAM: data for a strobed address is presented only during the
    // single cycle two clocks after the strobe; otherwise a junk pattern.
    logic        rd_p1;
    logic [10:0] addr_p1;
    always @(posedge MCLK) begin
        rd_p1   <= bus.BUFRD;
        addr_p1 <= bus.BUFADDR;
        bus.BUFDATA <= rd_p1 ? mem[addr_p1] : 16'hDEAD;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is usable once the target address has been
    // continuously active and unchanged for 5 sampled edges (a read issued
    // on the first edge plus the RAM round trip).
    int          m_age = 0;
    logic        m_prev_act = 1'b0;
    logic [10:0] m_prev_tgt = '0;
    logic [1:0]  m_dout = 2'b11;
    int          m_hold = 0;
    logic        m_under = 1'b0;
    logic        m_rd = 1'b0;
    logic [10:0] m_rd_addr = '0;

    always @(posedge MCLK) begin
        logic        act;
        logic [10:0] tgt;
        logic [15:0] w;
        int          p;
        act = bus.ACCTYPE[1] && (bus.BOUTCYCLENUM != 13'h1FFF);
        tgt = bus.ACCTYPE[0] ? 11'(1024 + int'(bus.BOUTCYCLENUM[12:3]))
                             : 11'(bus.BOUTCYCLENUM[12:3]);
        if (SYSRST) begin
            m_age = 0; m_prev_act = 1'b0; m_dout = 2'b11;
            m_hold = 0; m_under = 1'b0; m_rd = 1'b0;
        end else begin
            if (act && m_prev_act && tgt == m_prev_tgt) m_age++;
            else m_age = act ? 1 : 0;
            m_rd = act && (m_age == 1);
            m_rd_addr = tgt;
            if (!bus.ACCTYPE[2]) begin
                m_dout = 2'b11; m_hold = 0;
            end else if (!bus.nBOUTCLKEN) begin
                p = int'(bus.BOUTCYCLENUM[2:0]);
                w = mem[tgt];
                if (!bus.ACCTYPE[1] || !bus.nNOBUBBLE) m_dout = 2'b11;
                else if (m_age >= 5) m_dout = ~{w[2*p+1], w[2*p]};
                else begin m_dout = 2'b11; m_under = 1'b1; end
                m_hold = PULSE_LEN;
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_dout = 2'b11;
            end
            m_prev_act = act;
            m_prev_tgt = tgt;
        end
    end

    always @(negedge MCLK) begin
        check("dout", {14'd0, bus.DOUT}, {14'd0, m_dout});
        check("underrun", {15'd0, bus.UNDERRUN}, {15'd0, m_under});
        check("bufrd", {15'd0, bus.BUFRD}, {15'd0, m_rd});
        if (m_rd) check("bufaddr", {5'd0, bus.BUFADDR}, {5'd0, m_rd_addr});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic launch();
        bus.nBOUTCLKEN = 1'b0;
        tick(1);
        bus.nBOUTCLKEN = 1'b1;
    endtask

    logic [1:0] boot_exp [8];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        mem[0]    = 16'h0002;
        mem[1]    = 16'hA5C3;
        mem[2]    = 16'h0001;
        mem[1096] = 16'h8000;
        boot_exp = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01};

        SYSRST = 1'b1;
        bus.ACCTYPE = 3'b000;
        bus.BOUTCYCLENUM = 13'h1FFF;
        bus.nBOUTCLKEN = 1'b1;
        bus.nNOBUBBLE = 1'b1;
        tick(3);
        SYSRST = 1'b0;
        check("rst_dout", {14'd0, bus.DOUT}, 16'h0003);
        check("rst_bufrd", {15'd0, bus.BUFRD}, 16'h0000);
        check("rst_bufaddr", {5'd0, bus.BUFADDR}, 16'h0000);
        check("rst_underrun", {15'd0, bus.UNDERRUN}, 16'h0000);

        // BOOT read of word 1, all eight bit pairs
        bus.ACCTYPE = 3'b110;
        bus.BOUTCYCLENUM = 13'd8;
        tick(1);
        check("boot_rd", {15'd0, bus.BUFRD}, 16'h0001);
        check("boot_addr", {5'd0, bus.BUFADDR}, 16'd1);
        tick(6);
        for (int p = 0; p < 8; p++) begin
            bus.BOUTCYCLENUM = 13'(8 + p);
            tick(1);
            launch();
            check($sformatf("boot_p%0d", p), {14'd0, bus.DOUT}, {14'd0, boot_exp[p]});
            if (p == 0) begin
                tick(118);
                check("boot_hold", {14'd0, bus.DOUT}, 16'h0000);
                tick(2);
                check("boot_expire", {14'd0, bus.DOUT}, 16'h0003);
            end else begin
                tick(10);
            end
        end

        // Underrun: launch two cycles after a target change
        bus.BOUTCYCLENUM = 13'd16;
        tick(2);
        launch();
        check("under_dout", {14'd0, bus.DOUT}, 16'h0003);
        check("under_flag", {15'd0, bus.UNDERRUN}, 16'h0001);
        tick(10);
        launch();
        check("under_late_dout", {14'd0, bus.DOUT}, 16'h0002);
        check("under_sticky", {15'd0, bus.UNDERRUN}, 16'h0001);
        tick(5);

        // BOOT wrap 4105 -> 0
        bus.BOUTCYCLENUM = 13'd4105;
        tick(1);
        check("wrap_addr513", {5'd0, bus.BUFADDR}, 16'd513);
        tick(6);
        launch();
        tick(5);
        bus.BOUTCYCLENUM = 13'd0;
        tick(1);
        check("wrap_rd", {15'd0, bus.BUFRD}, 16'h0001);
        check("wrap_addr0", {5'd0, bus.BUFADDR}, 16'd0);
        tick(6);
        launch();
        check("wrap_dout", {14'd0, bus.DOUT}, 16'h0001);

        // Reset mid-pulse
        tick(20);
        SYSRST = 1'b1;
        tick(1);
        check("midrst_dout", {14'd0, bus.DOUT}, 16'h0003);
        check("midrst_bufrd", {15'd0, bus.BUFRD}, 16'h0000);
        check("midrst_underrun", {15'd0, bus.UNDERRUN}, 16'h0000);
        tick(2);
        SYSRST = 1'b0;
        tick(8);

        // Reset right after a read strobe; stale RAM data must be ignored
        bus.BOUTCYCLENUM = 13'd24;
        tick(1);
        SYSRST = 1'b1;
        tick(2);
        SYSRST = 1'b0;
        tick(8);
        launch();
        tick(5);

        // USER base and end of page
        bus.ACCTYPE = 3'b111;
        bus.BOUTCYCLENUM = 13'd0;
        tick(1);
        check("user_rd", {15'd0, bus.BUFRD}, 16'h0001);
        check("user_addr1024", {5'd0, bus.BUFADDR}, 16'd1024);
        tick(6);
        launch();
        tick(5);
        bus.BOUTCYCLENUM = 13'd583;
        tick(1);
        check("user_addr1096", {5'd0, bus.BUFADDR}, 16'd1096);
        tick(6);
        bus.nNOBUBBLE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            launch();
            check("user_nobubble", {14'd0, bus.DOUT}, 16'h0003);
            tick(4);
            check("user_no_refetch", {15'd0, bus.BUFRD}, 16'h0000);
        end
        bus.nNOBUBBLE = 1'b1;
        launch();
        check("user_last_word", {14'd0, bus.DOUT}, 16'h0001);
        tick(30);

        // Access end mid-pulse, coinciding with a launch strobe
        bus.ACCTYPE = 3'b000;
        launch();
        check("acc_end_dout", {14'd0, bus.DOUT}, 16'h0003);
        tick(5);
        // word_valid must have been dropped: a quick relaunch underruns
        bus.ACCTYPE = 3'b111;
        tick(2);
        launch();
        check("acc_end_invalid", {15'd0, bus.UNDERRUN}, 16'h0001);
        check("acc_end_relaunch", {14'd0, bus.DOUT}, 16'h0003);
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
